// File: rtl/fused_buf_pkg.sv
// Shared defaults, read-FSM state type and bank row helper for the
// interleaved feature-map read buffer.
package fused_buf_pkg;

  localparam int DATA_W = 64;
  localparam int LANES  = 8;
  localparam int DEPTH  = 4096;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rd_state_t;

  // Row read by bank 'lane' for a beat starting at word 'addr': the bank
  // supplies the first word at or after addr whose low bits equal lane.
  function automatic int unsigned bank_row(input int unsigned addr,
                                           input int unsigned lane,
                                           input int unsigned lanes,
                                           input int unsigned depth);
    int unsigned word;
    word = addr + ((lane - addr) & (lanes - 1));
    if (word >= depth) word = word - depth;
    return word / lanes;
  endfunction

endpackage

// File: rtl/bram_bank.sv
// One interleaved storage bank: simple dual-port block RAM with a gated,
// registered read-first output.
module bram_bank #(
  parameter int DATA_W = fused_buf_pkg::DATA_W,
  parameter int ROWS   = fused_buf_pkg::DEPTH / fused_buf_pkg::LANES,
  parameter int RW     = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [RW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [RW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [ROWS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Output register holds while i_re is low so a stalled beat is preserved.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wide_read_buffer.sv
// Banked feature-map buffer: narrow write port, LANES-word unaligned read
// beats issued as strided bursts with a valid/ready output handshake.
module wide_read_buffer #(
  parameter int DATA_W = fused_buf_pkg::DATA_W,
  parameter int LANES  = fused_buf_pkg::LANES,
  parameter int DEPTH  = fused_buf_pkg::DEPTH,
  parameter int CNT_W  = 12,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_start,
  input  logic [AW-1:0]           rd_base,
  input  logic [AW-1:0]           rd_stride,
  input  logic [CNT_W-1:0]        rd_count,
  output logic                    rd_busy,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_W*LANES-1:0] rd_data,
  output logic                    rd_last
);
  import fused_buf_pkg::*;

  localparam int LW   = $clog2(LANES);
  localparam int ROWS = DEPTH / LANES;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a,
                                             input logic [AW-1:0] b);
    logic [AW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= DEPTH_X) sum = sum - DEPTH_X;
    return sum[AW-1:0];
  endfunction

  rd_state_t        r_state, w_state_nxt;
  logic [AW-1:0]    r_addr, w_addr_nxt;
  logic [AW-1:0]    r_stride, w_stride_nxt;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;
  logic [AW-1:0]    w_issue_addr;
  logic             w_issue, w_issue_last;
  logic             w_adv0, w_adv1, w_adv2, w_xfer;

  logic                    r_vld_p0, r_vld_p1, r_vld_p2;
  logic                    r_last_p0, r_last_p1, r_last_p2;
  logic [LW-1:0]           r_rot_p0, r_rot_p1;
  logic [DATA_W-1:0]       w_q_p0 [LANES];
  logic [DATA_W-1:0]       r_q_p1 [LANES];
  logic [DATA_W*LANES-1:0] w_rot_p1;
  logic [DATA_W*LANES-1:0] r_data_p2;
  logic [RW-1:0]           w_rd_row [LANES];
  logic [LW-1:0]           w_wr_bank;
  logic [RW-1:0]           w_wr_row;

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_xfer = r_vld_p2 && rd_ready;
  assign w_adv2 = !r_vld_p2 || rd_ready;
  assign w_adv1 = !r_vld_p1 || w_adv2;
  assign w_adv0 = !r_vld_p0 || w_adv1;

  // Beat 0 is issued on the start edge itself, straight from rd_base.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_stride_nxt = r_stride;
    w_rem_nxt    = r_rem;
    w_issue      = 1'b0;
    w_issue_addr = r_addr;
    w_issue_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (rd_start && (rd_count != '0) && w_adv0) begin
          w_issue      = 1'b1;
          w_issue_addr = rd_base;
          w_issue_last = (rd_count == CNT_W'(1));
          w_addr_nxt   = wrap_add(rd_base, rd_stride);
          w_stride_nxt = rd_stride;
          w_rem_nxt    = rd_count - CNT_W'(1);
          w_state_nxt  = (rd_count == CNT_W'(1)) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (w_adv0) begin
          w_issue      = 1'b1;
          w_issue_last = (r_rem == CNT_W'(1));
          w_addr_nxt   = wrap_add(r_addr, r_stride);
          w_rem_nxt    = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_xfer && r_last_p2) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int b = 0; b < LANES; b++) begin
      w_rd_row[b] = RW'(bank_row(32'(w_issue_addr), b, LANES, DEPTH));
    end
  end

  assign w_wr_bank = wr_addr[LW-1:0];
  assign w_wr_row  = RW'(wr_addr >> LW);

  // ---- S0 -> S1 boundary: bank address registered, bank data valid in S1 ----
  for (genvar b = 0; b < LANES; b++) begin : g_bank
    bram_bank #(
      .DATA_W (DATA_W),
      .ROWS   (ROWS),
      .RW     (RW)
    ) u_bank (
      .clk     (clk),
      .i_we    (wr_en && (w_wr_bank == LW'(b))),
      .i_waddr (w_wr_row),
      .i_wdata (wr_data),
      .i_re    (w_issue),
      .i_raddr (w_rd_row[b]),
      .o_rdata (w_q_p0[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_stride  <= '0;
      r_rem     <= '0;
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_last_p0 <= 1'b0;
      r_last_p1 <= 1'b0;
      r_last_p2 <= 1'b0;
      r_data_p2 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_stride <= w_stride_nxt;
      r_rem    <= w_rem_nxt;
      if (w_adv0) begin
        r_vld_p0  <= w_issue;
        r_last_p0 <= w_issue_last;
      end
      if (w_adv1) begin
        r_vld_p1  <= r_vld_p0;
        r_last_p1 <= r_last_p0 && r_vld_p0;
      end
      if (w_adv2) begin
        r_vld_p2  <= r_vld_p1;
        r_last_p2 <= r_last_p1 && r_vld_p1;
        if (r_vld_p1) r_data_p2 <= w_rot_p1;
      end
    end
  end

  // ---- S1 boundary: bank outputs and rotate amount captured ----
  always_ff @(posedge clk) begin
    if (w_adv0 && w_issue) r_rot_p0 <= w_issue_addr[LW-1:0];
    if (w_adv1) begin
      r_q_p1   <= w_q_p0;
      r_rot_p1 <= r_rot_p0;
    end
  end

  // ---- S2 boundary: lane j takes the bank holding word beat_addr + j ----
  always_comb begin
    w_rot_p1 = '0;
    for (int j = 0; j < LANES; j++) begin
      w_rot_p1[j*DATA_W +: DATA_W] = r_q_p1[LW'(j) + r_rot_p1];
    end
  end

  assign rd_busy  = (r_state != IDLE);
  assign rd_valid = r_vld_p2;
  assign rd_last  = r_last_p2;
  assign rd_data  = r_data_p2;

endmodule

// File: tb/tb_wide_read_buffer.sv
// Directed bench for wide_read_buffer: RAM holds value = address, beats are
// checked against that arithmetic model cycle by cycle.
module tb_wide_read_buffer;
  localparam int DW    = 64;
  localparam int L     = 8;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int CW    = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_start = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic [AW-1:0] rd_stride = '0;
  logic [CW-1:0] rd_count = '0;
  logic          rd_busy;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic [DW*L-1:0] rd_data;
  logic          rd_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wide_read_buffer #(
    .DATA_W (DW),
    .LANES  (L),
    .DEPTH  (DEPTH),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_start  (rd_start),
    .rd_base   (rd_base),
    .rd_stride (rd_stride),
    .rd_count  (rd_count),
    .rd_busy   (rd_busy),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [DW*L-1:0] obs, input logic [DW*L-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*L-1:0] beat_exp(input int addr);
    logic [DW*L-1:0] v;
    v = '0;
    for (int j = 0; j < L; j++) v[j*DW +: DW] = 64'((addr + j) % DEPTH);
    return v;
  endfunction

  task automatic chk_beat(input string tag, input int addr);
    chk_wide(tag, rd_data, beat_exp(addr));
  endtask

  task automatic start_burst(input int base, input int stride, input int count);
    rd_start  = 1'b1;
    rd_base   = AW'(base);
    rd_stride = AW'(stride);
    rd_count  = CW'(count);
    tick();
    rd_start  = 1'b0;
  endtask

  // Collects beats for max_cyc cycles; bp selects the 1,0,0,1,0,1,... ready pattern.
  task automatic collect(input string tag, input int base, input int stride,
                         input int exp_n, input bit bp, input int max_cyc);
    int n;
    bit stall;
    logic [DW*L-1:0] held;
    logic held_last;
    n = 0;
    stall = 1'b0;
    held = '0;
    held_last = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      rd_ready = bp ? ((c == 0) || (c >= 3 && (c % 2) == 1)) : 1'b1;
      if (stall) begin
        chk({tag, "_hold_vld"}, 64'(rd_valid), 64'd1);
        chk_wide({tag, "_hold_data"}, rd_data, held);
        chk({tag, "_hold_last"}, 64'(rd_last), 64'(held_last));
      end
      stall = 1'b0;
      if (rd_valid && rd_ready) begin
        chk({tag, "_no_extra"}, 64'(n < exp_n), 64'd1);
        if (n < exp_n) begin
          chk_beat({tag, "_beat"}, (base + n * stride) % DEPTH);
          chk({tag, "_last"}, 64'(rd_last), 64'(n == exp_n - 1));
        end
        n++;
      end else if (rd_valid) begin
        stall = 1'b1;
        held = rd_data;
        held_last = rd_last;
      end
      tick();
    end
    rd_ready = 1'b1;
    chk({tag, "_count"}, 64'(n), 64'(exp_n));
    chk({tag, "_busy_end"}, 64'(rd_busy), 64'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", 64'(rd_busy), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_last", 64'(rd_last), 64'd0);
    chk_wide("rst_data", rd_data, '0);
    rst = 1'b0;

    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1;
      wr_addr = AW'(a);
      wr_data = 64'(a);
      tick();
    end
    wr_en = 1'b0;
    tick();

    // Aligned burst: base 0, stride 8, count 4.
    start_burst(0, 8, 4);
    chk("al_busy0", 64'(rd_busy), 64'd1);
    chk("al_vld0", 64'(rd_valid), 64'd0);
    tick();
    chk("al_vld1", 64'(rd_valid), 64'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("al_vld", 64'(rd_valid), 64'd1);
      chk_beat("al_beat", 8 * k);
      chk("al_last", 64'(rd_last), 64'(k == 3));
      chk("al_busy", 64'(rd_busy), 64'd1);
      tick();
    end
    chk("al_busy_after", 64'(rd_busy), 64'd0);
    chk("al_vld_after", 64'(rd_valid), 64'd0);

    // Unaligned single beat wrapping past the top of memory.
    start_burst(4093, 1, 1);
    tick();
    chk("un_vld1", 64'(rd_valid), 64'd0);
    tick();
    chk("un_vld", 64'(rd_valid), 64'd1);
    chk("un_lane0", rd_data[63:0], 64'd4093);
    chk("un_lane3", rd_data[255:192], 64'd0);
    chk("un_lane7", rd_data[511:448], 64'd4);
    chk_beat("un_beat", 4093);
    chk("un_last", 64'(rd_last), 64'd1);
    tick();
    chk("un_busy_after", 64'(rd_busy), 64'd0);
    chk("un_vld_after", 64'(rd_valid), 64'd0);

    // Backpressure.
    start_burst(5, 1, 6);
    collect("bp", 5, 1, 6, 1'b1, 40);

    // Zero count is a no-op.
    start_burst(0, 1, 0);
    for (int c = 0; c < 4; c++) begin
      chk("z_busy", 64'(rd_busy), 64'd0);
      chk("z_vld", 64'(rd_valid), 64'd0);
      tick();
    end

    // A second start while busy is ignored.
    start_burst(0, 1, 3);
    rd_start  = 1'b1;
    rd_base   = AW'(200);
    rd_stride = AW'(2);
    rd_count  = CW'(5);
    tick();
    rd_start  = 1'b0;
    collect("ign", 0, 1, 3, 1'b0, 12);

    // Reset during an 8-beat burst.
    start_burst(100, 3, 8);
    tick();
    tick();
    chk("rs_vld_b0", 64'(rd_valid), 64'd1);
    chk_beat("rs_beat0", 100);
    tick();
    chk_beat("rs_beat1", 103);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_vld", 64'(rd_valid), 64'd0);
    chk("rs_busy", 64'(rd_busy), 64'd0);
    chk("rs_last", 64'(rd_last), 64'd0);
    chk_wide("rs_data", rd_data, '0);
    for (int c = 0; c < 4; c++) begin
      chk("rs_quiet", 64'(rd_valid), 64'd0);
      tick();
    end
    start_burst(100, 3, 3);
    collect("rs_again", 100, 3, 3, 1'b0, 12);

    // Read/write collision on the start edge.
    wr_en   = 1'b1;
    wr_addr = AW'(16);
    wr_data = 64'hDEAD;
    start_burst(16, 0, 2);
    wr_en   = 1'b0;
    tick();
    tick();
    chk("col_vld0", 64'(rd_valid), 64'd1);
    chk("col_b0_lane0", rd_data[63:0], 64'd16);
    chk_beat("col_b0", 16);
    chk("col_b0_last", 64'(rd_last), 64'd0);
    tick();
    chk("col_vld1", 64'(rd_valid), 64'd1);
    chk("col_b1_lane0", rd_data[63:0], 64'hDEAD);
    chk("col_b1_lane1", rd_data[127:64], 64'd17);
    chk("col_b1_last", 64'(rd_last), 64'd1);
    tick();
    chk("col_busy_after", 64'(rd_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
